// File: rtl/text_buffer_ctrl_pkg.sv
// ============================================================================
//  text_pkg : shared opcodes, character codes and printable-range rule
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package text_pkg;

    localparam logic [1:0] OP_PUT = 2'b00;
    localparam logic [1:0] OP_BS  = 2'b01;
    localparam logic [1:0] OP_NL  = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [6:0] BLANK_CHAR = 7'h20;
    localparam logic [6:0] SUB_CHAR   = 7'h2D;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // Bit 7 takes part in the range test, so codes >= 0x80 are substituted.
    function automatic logic [6:0] sanitize_char(input logic [7:0] c, input logic [6:0] sub);
        return ((c >= PRINT_MIN) && (c <= PRINT_MAX)) ? c[6:0] : sub;
    endfunction

endpackage

`default_nettype wire

// File: rtl/text_buffer_ctrl_if.sv
// ============================================================================
//  text_cmd_if : character-entry command channel (valid/ready)
//  Rev 1.0     : initial release
// ============================================================================
`default_nettype none

interface text_cmd_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_char;

    modport master (output cmd_valid, output cmd_op, output cmd_char, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_char, output cmd_ready);

endinterface

`default_nettype wire

// File: rtl/text_ram.sv
// ============================================================================
//  text_ram : simple dual-port RAM, synchronous write, registered read
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module text_ram #(
    parameter int             AW        = 7,
    parameter int             DW        = 7,
    parameter logic [DW-1:0]  RESET_VAL = '0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= RESET_VAL;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
// ============================================================================
//  text_buffer_ctrl : text-overlay character buffer with cursor and clear FSM
//  Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module text_buffer_ctrl #(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 4,
    parameter logic [6:0] BLANK_CHAR = 7'h20,
    parameter logic [6:0] SUB_CHAR   = 7'h2D
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    text_cmd_if.slave                    cmd,
    input  wire logic [$clog2(COLS)-1:0] rd_col,
    input  wire logic [$clog2(ROWS)-1:0] rd_row,
    output logic      [6:0]              rd_char,
    output logic      [$clog2(COLS)-1:0] cursor_col,
    output logic      [$clog2(ROWS)-1:0] cursor_row,
    output logic                         busy
);

    import text_pkg::OP_PUT;
    import text_pkg::OP_BS;
    import text_pkg::OP_NL;
    import text_pkg::OP_CLR;
    import text_pkg::sanitize_char;

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = CW + RW;
    localparam logic [AW-1:0] LAST_CELL = AW'(COLS*ROWS - 1);

    localparam logic [0:0] ST_CLEARING = 1'b0;
    localparam logic [0:0] ST_IDLE     = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [AW-1:0] clr_ptr, clr_ptr_nxt;
    logic [AW-1:0] cursor, cursor_nxt;      // flat {row,col} cell index
    logic          accept;
    logic          we;
    logic [AW-1:0] waddr;
    logic [6:0]    wdata;

    assign accept     = cmd.cmd_valid && cmd.cmd_ready;
    assign cursor_col = cursor[CW-1:0];
    assign cursor_row = cursor[AW-1:CW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEARING;
            clr_ptr <= '0;
            cursor  <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            cursor  <= cursor_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        cursor_nxt  = cursor;
        if (state == ST_CLEARING) begin
            clr_ptr_nxt = clr_ptr + AW'(1);
            if (clr_ptr == LAST_CELL) begin
                state_nxt   = ST_IDLE;
                clr_ptr_nxt = '0;
                cursor_nxt  = '0;
            end
        end else if (accept) begin
            case (cmd.cmd_op)
                OP_PUT: cursor_nxt = cursor + AW'(1);
                OP_BS: begin
                    if (cursor != '0) begin
                        cursor_nxt = cursor - AW'(1);
                    end
                end
                OP_NL:  cursor_nxt = {cursor[AW-1:CW] + RW'(1), CW'(0)};
                OP_CLR: begin
                    state_nxt   = ST_CLEARING;
                    clr_ptr_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd.cmd_ready = (state == ST_IDLE);
        busy          = (state == ST_CLEARING);
        we            = 1'b0;
        waddr         = cursor;
        wdata         = BLANK_CHAR;
        if (state == ST_CLEARING) begin
            we    = 1'b1;
            waddr = clr_ptr;
        end else if (accept) begin
            case (cmd.cmd_op)
                OP_PUT: begin
                    we    = 1'b1;
                    wdata = sanitize_char(cmd.cmd_char, SUB_CHAR);
                end
                OP_BS: begin
                    // Blank lands on the cell the cursor is moving back onto.
                    if (cursor != '0) begin
                        we    = 1'b1;
                        waddr = cursor - AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    text_ram #(
        .AW        (AW),
        .DW        (7),
        .RESET_VAL (BLANK_CHAR)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   ({rd_row, rd_col}),
        .rdata   (rd_char)
    );

endmodule

`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
// ============================================================================
//  tb_text_buffer_ctrl : directed self-checking bench for text_buffer_ctrl
//  Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_text_buffer_ctrl;

    import text_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [4:0] rd_col;
    logic [1:0] rd_row;
    logic [6:0] rd_char;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    text_cmd_if cmd_if();

    text_buffer_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd_if),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_char    (rd_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] ch);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_char  = ch;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic read_cell(input int idx, output logic [6:0] d);
        @(negedge clk);
        rd_row = idx[6:5];
        rd_col = idx[4:0];
        @(posedge clk);
        #1;
        d = rd_char;
    endtask

    // Counts cycles with busy high, sampled at falling edges; records cursor at sample 60.
    task automatic count_busy(output int n, output int cur_mid);
        n       = 0;
        cur_mid = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == 60) cur_mid = {cursor_row, cursor_col};
        end
    endtask

    task automatic check_cells(input string tag, input int sp_idx, input logic [6:0] sp_val);
        logic [6:0] d;
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            read_cell(i, d);
            if (d !== ((i == sp_idx) ? sp_val : 7'h20)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic [6:0] d;
        int n, mid;

        reset_n          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_PUT;
        cmd_if.cmd_char  = 8'h00;
        rd_col           = '0;
        rd_row           = '0;

        // 1: reset state and initial clear
        #12;
        check("rst_busy",    busy, 1);
        check("rst_ready",   cmd_if.cmd_ready, 0);
        check("rst_cursor",  {cursor_row, cursor_col}, 0);
        check("rst_rd_char", rd_char, 7'h20);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        count_busy(n, mid);
        check("init_clear_len", n, 128);
        check("init_ready",     cmd_if.cmd_ready, 1);
        check("init_cursor",    {cursor_row, cursor_col}, 0);
        check_cells("init_all_blank", -1, 7'h20);

        // 2: back-to-back puts
        send(OP_PUT, 8'h41);
        send(OP_PUT, 8'h42);
        send(OP_PUT, 8'h43);
        check("abc_cursor", {cursor_row, cursor_col}, 3);
        read_cell(0, d); check("cell_0_0", d, 7'h41);
        read_cell(1, d); check("cell_0_1", d, 7'h42);
        read_cell(2, d); check("cell_0_2", d, 7'h43);

        // 3: substitution of non-printables
        send(OP_PUT, 8'h7F);
        send(OP_PUT, 8'h85);
        send(OP_PUT, 8'h7E);
        read_cell(3, d); check("sub_7f", d, 7'h2D);
        read_cell(4, d); check("sub_85", d, 7'h2D);
        read_cell(5, d); check("keep_7e", d, 7'h7E);
        check("sub_cursor", {cursor_row, cursor_col}, 6);

        // 4: backspace, row wrap, full wrap
        for (int i = 0; i < 6; i++) send(OP_BS, 8'h00);
        check("bs6_cursor", {cursor_row, cursor_col}, 0);
        read_cell(5, d); check("bs_blank_0_5", d, 7'h20);
        read_cell(0, d); check("bs_blank_0_0", d, 7'h20);
        for (int i = 0; i < 32; i++) send(OP_PUT, 8'h61);
        check("row_wrap_cursor", {cursor_row, cursor_col}, {2'd1, 5'd0});
        send(OP_BS, 8'h00);
        check("bs_row_cursor", {cursor_row, cursor_col}, {2'd0, 5'd31});
        read_cell(31, d); check("bs_row_blank", d, 7'h20);
        read_cell(30, d); check("bs_row_keep", d, 7'h61);
        for (int i = 0; i < 31; i++) send(OP_BS, 8'h00);
        for (int i = 0; i < 128; i++) send(OP_PUT, 8'h30 + 8'(i % 64));
        check("full_wrap_cursor", {cursor_row, cursor_col}, 0);
        read_cell(127, d); check("cell_3_31", d, 7'h6F);
        send(OP_BS, 8'h00);
        check("bs_origin_cursor", {cursor_row, cursor_col}, 0);
        read_cell(0, d);   check("bs_origin_keep_0", d, 7'h30);
        read_cell(127, d); check("bs_origin_keep_127", d, 7'h6F);

        // 5: newline from (3,17), then clear with a held command
        for (int i = 0; i < 3; i++) send(OP_NL, 8'h00);
        check("nl3_cursor", {cursor_row, cursor_col}, {2'd3, 5'd0});
        for (int i = 0; i < 17; i++) send(OP_PUT, 8'h5A);
        check("pre_nl_cursor", {cursor_row, cursor_col}, {2'd3, 5'd17});
        send(OP_NL, 8'h00);
        check("nl_wrap_cursor", {cursor_row, cursor_col}, 0);
        read_cell(113, d); check("nl_no_write_113", d, 7'h61);
        read_cell(0, d);   check("nl_no_write_0", d, 7'h30);
        send(OP_PUT, 8'h41);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_CLR;
        @(posedge clk);
        #1;
        cmd_if.cmd_op   = OP_PUT;
        cmd_if.cmd_char = 8'h55;
        count_busy(n, mid);
        check("clr_len",         n, 128);
        check("clr_cursor_hold", mid, 1);
        check("clr_end_cursor",  {cursor_row, cursor_col}, 0);
        check("clr_end_ready",   cmd_if.cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check("held_put_cursor", {cursor_row, cursor_col}, 1);
        check_cells("clr_all_blank", 0, 7'h55);

        // 6: asynchronous reset in the middle of a clear
        for (int i = 0; i < 3; i++) send(OP_NL, 8'h00);
        send(OP_PUT, 8'h47);
        check("pre_rst_cursor", {cursor_row, cursor_col}, {2'd3, 5'd1});
        @(negedge clk);
        rd_row = 2'd3;
        rd_col = 5'd0;
        send(OP_CLR, 8'h00);
        repeat (60) @(posedge clk);
        #2;
        check("mid_clr_busy",    busy, 1);
        check("mid_clr_rd_char", rd_char, 7'h47);
        reset_n = 1'b0;
        #1;
        check("arst_busy",    busy, 1);
        check("arst_ready",   cmd_if.cmd_ready, 0);
        check("arst_cursor",  {cursor_row, cursor_col}, 0);
        check("arst_rd_char", rd_char, 7'h20);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        count_busy(n, mid);
        check("re_clear_len",    n, 128);
        check("re_clear_ready",  cmd_if.cmd_ready, 1);
        check("re_clear_cursor", {cursor_row, cursor_col}, 0);
        read_cell(96, d); check("re_clear_cell_96", d, 7'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
